// File: rtl/spi_receive.sv
// SPI mode-3 byte receiver: oversampled sclk/sdi/cs, valid/ack output stage, framing/overrun flags.
// Define SPI_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module spi_receive #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sdi,
  input  logic       cs,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       frame_active,
  output logic       done,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("spi_receive: SYNC_STAGES must be 2 or 3");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_receive: FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sdi_sync_q, cs_sync_q, fill_q;
  logic                   sclk_d_q, cs_d_q, armed_q;
  logic                   sclk_s, sdi_s, cs_s;
  logic                   sclk_rise, cs_rise, cs_fall;
  logic                   sclk_rise_q, sdi_q;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  // Only bits 7..1 are stored; bit 0 comes straight from sdi_q when the byte completes.
  logic [6:0] shift_q;
  logic       done_q, frame_err_q, overrun_q;

  logic       byte_push, push_ok, drop;
  logic [7:0] push_byte;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d_q;
  assign cs_rise   = cs_s & ~cs_d_q;
  assign cs_fall   = ~cs_s & cs_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '1;
      sdi_sync_q  <= '1;
      cs_sync_q   <= '1;
      sclk_d_q    <= 1'b1;
      cs_d_q      <= 1'b1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      sclk_rise_q <= 1'b0;
      sdi_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_d_q    <= sclk_s;
      cs_d_q      <= cs_s;
      // Arm only once a genuine post-reset sample of cs has reached the chain end as high.
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
      sclk_rise_q <= sclk_rise;
      sdi_q       <= sdi_s;
    end
  end

  assign frame_active = ~cs_s;

  assign byte_push = (state_q == StShift) & ~cs_rise & sclk_rise_q & (bit_cnt_q == 3'd7);
  assign push_byte = {shift_q, sdi_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          bit_cnt_q <= 3'd0;
          if (cs_fall && armed_q) begin
            state_q <= StShift;
          end
        end
        StShift: begin
          if (cs_rise) begin
            state_q     <= StIdle;
            done_q      <= 1'b1;
            frame_err_q <= (bit_cnt_q != 3'd0);
            bit_cnt_q   <= 3'd0;
          end else if (sclk_rise_q) begin
            shift_q   <= {shift_q[5:0], sdi_q};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
      endcase
    end
  end

  assign done      = done_q;
  assign frame_err = frame_err_q;

`ifdef SPI_RX_FIFO_EN
  localparam int unsigned Aw = $clog2(FIFO_DEPTH);

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [Aw:0] wptr_q, rptr_q;
  logic        empty, full, pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign pop     = ~empty & data_ack;
  assign push_ok = byte_push & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push_ok) begin
        mem_q[wptr_q[Aw-1:0]] <= push_byte;
        wptr_q                <= wptr_q + 1'b1;
      end
    end
  end

  assign data       = mem_q[rptr_q[Aw-1:0]];
  assign data_valid = ~empty;
`else
  logic [7:0] hold_q;
  logic       valid_q, pop;

  assign pop     = valid_q & data_ack;
  assign push_ok = byte_push & (~valid_q | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= 8'h00;
      valid_q <= 1'b0;
    end else if (push_ok) begin
      hold_q  <= push_byte;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign data       = hold_q;
  assign data_valid = valid_q;
`endif

  assign drop = byte_push & ~push_ok;

  // A drop in the same cycle as err_clr leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= drop | (overrun_q & ~err_clr);
    end
  end

  assign overrun = overrun_q;

endmodule

// File: doc/spi_receive.md
# spi_receive

Serial-to-parallel SPI receiver for the serial controller. It is the receiving end of the controller's SPI byte link: mode 3, MSB first, active-low chip select, with SCLK at one quarter of the system clock or slower. It oversamples `sclk`, `sdi` and `cs` on the system clock and reassembles bytes. It hands each byte to the consumer through a valid/ack handshake, with an optional FIFO, and flags framing and overrun errors.

## Interface
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth on `sclk`, `sdi` and `cs`; legal range 2–3.
- `FIFO_DEPTH`, default 4: output FIFO depth; power of two, 2–16; used only with `SPI_RX_FIFO_EN`.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sclk` input 1: serial clock; idles high; asynchronous to `clk`.
- `sdi` input 1: serial data; sampled on `sclk` rising edges.
- `cs` input 1: chip select, active low.
- `data` output 8: received byte; valid while `data_valid` is high.
- `data_valid` output 1: a byte is available.
- `data_ack` input 1: consumer takes the byte when `data_valid && data_ack`.
- `frame_active` output 1: synchronized `cs` is low.
- `done` output 1: one-cycle pulse on the synchronized `cs` rising edge.
- `frame_err` output 1: one-cycle pulse when `cs` deasserts with 1–7 bits shifted.
- `overrun` output 1: sticky; set when a completed byte is dropped.
- `err_clr` input 1: clears `overrun` synchronously.

## Operation
- Each input passes through its own `SYNC_STAGES` synchronizer.
- Edges are detected by comparing the last synchronizer stage with one extra delay register.
- FSM states:
  - IDLE: synchronized `cs` is high. `bit_cnt` is held at 0.
  - SHIFT: synchronized `cs` is low. Each `sclk` rising edge shifts the synchronized `sdi` into an 8-bit shift register (MSB first) and increments the 3-bit `bit_cnt`.
- Transitions:
  - IDLE→SHIFT on a `cs` falling edge.
  - SHIFT→IDLE on a `cs` rising edge. That edge pulses `done`; it also pulses `frame_err` if `bit_cnt != 0`, and the partial byte is discarded.
- `sclk` edges are ignored while in IDLE. A `sclk` edge in the same cycle as the `cs` rising edge is ignored.
- Byte complete: when `bit_cnt` wraps 7→0, the assembled byte (`{shift[6:0], sdi}`) is pushed to the output stage. `cs` may stay low across consecutive bytes.
- Push with a full output stage: the new byte is dropped, the stored data is unchanged, and `overrun` is set.
- Push and `data_ack` in the same cycle on a full stage: the pop happens first, so the push succeeds and there is no overrun.
- `err_clr` and an overrun in the same cycle: `overrun` is set (set wins).
- Reset values: `data` 8'h00; `data_valid`, `done`, `frame_err`, `overrun` all 0; `frame_active` 0; FSM in IDLE; shift register, `bit_cnt` and FIFO pointers all 0.
- Reset mid-byte discards the partial byte and all stored bytes.
- After reset, `cs` must be seen high before the first frame is accepted. The synchronizers reset to 1, so a `cs` held low through reset is not treated as a falling edge.

## Timing
- Input latency: `SYNC_STAGES`+1 cycles from `sclk`/`cs` at the pins to edge detection.
- `sdi` is taken from the same synchronizer stage as `sclk`. The transmitter changes `sdi` two `clk` cycles before the `sclk` rise, which gives the required margin.
- Minimum `sclk` high and low time: 2 `clk` cycles each.
- Byte latency:
  - `data_valid` rises `SYNC_STAGES`+2 cycles after the cycle in which raw `sclk` is first sampled high for bit 0 (LSB).
  - `data` is stable in that same cycle.
- `data_valid` stays high until a cycle with `data_ack` high. The next stored byte, if any, appears the following cycle.
- `done` and `frame_err` are asserted in the same cycle: `SYNC_STAGES`+1 cycles after raw `cs` rises.

## Configuration
- `SPI_RX_FIFO_EN` defined:
  - The output stage is a `FIFO_DEPTH`-entry FIFO, and "full" means `FIFO_DEPTH` bytes are held.
  - `data` is the FIFO head.
  - `data_valid` is high when the FIFO is not empty.
  - Pointers are `$clog2(FIFO_DEPTH)+1` bits wide, including a wrap bit.
- `SPI_RX_FIFO_EN` undefined:
  - The output stage is a single holding register, and "full" means `data_valid` is high.
  - `FIFO_DEPTH` is ignored.

## Test plan
- Reset, then send 8'hA5 in one frame at SCLK = `clk`/4 → `data`=8'hA5 and `data_valid` high at the specified latency; `done` pulses once; `frame_err` stays 0.
- Keep `cs` low and send 8'h3C then 8'hC3 back-to-back, with `data_ack` held high → two valid cycles showing 8'h3C then 8'hC3; a single `done` pulse after `cs` rises.
- Send 5 bits (10110) then raise `cs` → `frame_err` pulses once; `data_valid` stays 0; the next full byte 8'h81 is received correctly.
- Hold `data_ack` low and send 8'h11, 8'h22, … → without FIFO: 8'h11 is held and `overrun` sets on the 2nd byte. With FIFO: `overrun` sets on the byte after the 4th, and 8'h11–8'h44 drain in order. `err_clr` then clears `overrun`.
- Assert `data_ack` in the exact cycle the next byte completes into a full stage → no overrun; the new byte is presented in the following cycle.
- Assert `rst` after bit 3 of a byte, then release it and send 8'h5A → no `data_valid` for the partial byte; 8'h5A is received correctly.
